corr_engine: RTL and testbench

- Parametrised correlation engine: two TAPS-deep sample buffers (window, filter) loaded WR_LANES words per write; self-sequenced multiply-accumulate over all taps.
- Start/busy/done handshake with selectable wrap or saturate accumulation and an overflow flag.
- Sits between the window/filter load controller and the result collector; replaces externally indexed MAC sequencing with an internal FSM.

---
 rtl/corr_engine.sv | 142 ++++++++++++++
 tb/tb_corr_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_engine.sv
// Self-sequenced MAC over TAPS window/filter pairs; result TAPS+2 cycles after start, one-cycle done pulse.
// No backpressure: buffer writes are accepted only when idle, dropped (and flagged in wr_drop) otherwise.
module corr_engine #(
  parameter int DATA_W   = 8,
  parameter int TAPS     = 16,
  parameter int WR_LANES = 4,
  parameter int ACC_W    = 12,
  parameter int AW       = (TAPS / WR_LANES > 1) ? $clog2(TAPS / WR_LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] window_buff_in [0:WR_LANES-1],
  input  logic              write_window_buff_en,
  input  logic [AW-1:0]     write_window_buff_ind,
  input  logic [DATA_W-1:0] filter_buff_in [0:WR_LANES-1],
  input  logic              write_filter_buff_en,
  input  logic [AW-1:0]     write_filter_buff_ind,
  input  logic              start,
  input  logic              sat_en,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  mac_out,
  output logic              ovf,
  output logic              wr_drop
);

  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] win_q  [TAPS];
  logic [DATA_W-1:0] filt_q [TAPS];
  logic [IW-1:0]     idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  mac_q, mac_d;
  logic              ovf_int_q, ovf_int_d;
  logic              ovf_q, ovf_d;
  logic              sat_q, sat_d;
  logic              done_q, done_d;
  logic              wr_drop_q, wr_drop_d;
  logic              idle;
  logic [PW-1:0]     prod;
  logic [SW-1:0]     sum;

  assign idle = (state_q == IDLE);
  assign prod = win_q[idx_q] * filt_q[idx_q];
  assign sum  = SW'(acc_q) + SW'(prod);

  // Buffer writes land at the same edge that may accept a start, so a
  // same-cycle write is visible to the run from its first tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= '{default: '0};
      filt_q <= '{default: '0};
    end else if (idle) begin
      for (int i = 0; i < WR_LANES; i++) begin
        if (write_window_buff_en)
          win_q[IW'(int'(write_window_buff_ind) * WR_LANES + i)] <= window_buff_in[i];
        if (write_filter_buff_en)
          filt_q[IW'(int'(write_filter_buff_ind) * WR_LANES + i)] <= filter_buff_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      mac_q     <= '0;
      ovf_int_q <= 1'b0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      mac_q     <= mac_d;
      ovf_int_q <= ovf_int_d;
      ovf_q     <= ovf_d;
      sat_q     <= sat_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mac_d     = mac_q;
    ovf_int_d = ovf_int_q;
    ovf_d     = ovf_q;
    sat_d     = sat_q;
    done_d    = 1'b0;
    wr_drop_d = wr_drop_q | (!idle & (write_window_buff_en | write_filter_buff_en));
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          idx_d     = '0;
          acc_d     = '0;
          ovf_int_d = 1'b0;
          sat_d     = sat_en;
          wr_drop_d = 1'b0;
        end
      end
      RUN: begin
        // Saturation stays sticky: at ACC_MAX any further sum is >= ACC_MAX.
        if (sum > SW'(ACC_MAX)) begin
          ovf_int_d = 1'b1;
          acc_d     = sat_q ? ACC_MAX : sum[ACC_W-1:0];
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(TAPS - 1))
          state_d = DONE;
      end
      DONE: begin
        mac_d   = acc_q;
        ovf_d   = ovf_int_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = !idle;
  assign done    = done_q;
  assign mac_out = mac_q;
  assign ovf     = ovf_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_corr_engine.sv
// Directed bench for corr_engine: a run-level model predicts outputs each cycle,
// and hand-computed literals pin the model on the key scenarios.
module tb_corr_engine;

  localparam int DATA_W   = 8;
  localparam int TAPS     = 16;
  localparam int WR_LANES = 4;
  localparam int ACC_W    = 12;
  localparam int AW       = 2;
  localparam int MAXV     = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] win_in  [0:WR_LANES-1];
  logic [DATA_W-1:0] filt_in [0:WR_LANES-1];
  logic              we_w, we_f;
  logic [AW-1:0]     ind_w, ind_f;
  logic              start, sat_en;
  logic              busy, done, ovf, wr_drop;
  logic [ACC_W-1:0]  mac_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Model state: buffers, cycles remaining in the current run, pending result.
  int m_win  [TAPS];
  int m_filt [TAPS];
  int m_left = 0;
  int r_res  = 0;
  bit r_ovf  = 0;
  int m_mac  = 0;
  bit m_ovf  = 0;
  bit m_done = 0;
  bit m_drop = 0;

  corr_engine #(
    .DATA_W(DATA_W), .TAPS(TAPS), .WR_LANES(WR_LANES), .ACC_W(ACC_W), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .window_buff_in(win_in),
    .write_window_buff_en(we_w),
    .write_window_buff_ind(ind_w),
    .filter_buff_in(filt_in),
    .write_filter_buff_en(we_f),
    .write_filter_buff_ind(ind_f),
    .start(start),
    .sat_en(sat_en),
    .busy(busy),
    .done(done),
    .mac_out(mac_out),
    .ovf(ovf),
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic corr(input bit sat, output int res, output bit ov);
    int acc;
    int s;
    acc = 0;
    ov  = 0;
    for (int t = 0; t < TAPS; t++) begin
      s = acc + m_win[t] * m_filt[t];
      if (s > MAXV) begin
        ov  = 1;
        acc = sat ? MAXV : (s % (MAXV + 1));
      end else begin
        acc = s;
      end
    end
    res = acc;
  endtask

  always @(posedge clk) begin
    bit was_idle;
    was_idle = (m_left == 0);
    if (rst) begin
      for (int t = 0; t < TAPS; t++) begin
        m_win[t]  = 0;
        m_filt[t] = 0;
      end
      m_left = 0; m_mac = 0; m_ovf = 0; m_done = 0; m_drop = 0;
    end else begin
      m_done = 0;
      if (m_left == 1) begin
        m_mac  = r_res;
        m_ovf  = r_ovf;
        m_done = 1;
      end
      if (m_left != 0) m_left--;
      if (was_idle) begin
        for (int i = 0; i < WR_LANES; i++) begin
          if (we_w) m_win[int'(ind_w) * WR_LANES + i] = int'(win_in[i]);
          if (we_f) m_filt[int'(ind_f) * WR_LANES + i] = int'(filt_in[i]);
        end
        if (start) begin
          corr(sat_en, r_res, r_ovf);
          m_left = TAPS + 1;
          m_drop = 0;
        end
      end else if (we_w || we_f) begin
        m_drop = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("mac_out", 32'(mac_out), 32'(m_mac));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("wr_drop", 32'(wr_drop), 32'(m_drop));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One write beat, lanes = base + step*lane.
  task automatic wr(input bit f, input int ind, input int base, input int step);
    for (int i = 0; i < WR_LANES; i++) begin
      if (f) filt_in[i] = 8'(base + step * i);
      else   win_in[i]  = 8'(base + step * i);
    end
    if (f) begin we_f = 1; ind_f = 2'(ind); end
    else   begin we_w = 1; ind_w = 2'(ind); end
    tick(1);
    we_w = 0;
    we_f = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: no done within 40 cycles, expected one", nm);
    end
  endtask

  task automatic run(input bit s, input string nm);
    start  = 1;
    sat_en = s;
    tick(1);
    start = 0;
    wait_done(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int dcnt;
    rst = 1; we_w = 0; we_f = 0; ind_w = 0; ind_f = 0; start = 0; sat_en = 0;
    for (int i = 0; i < WR_LANES; i++) begin
      win_in[i]  = 0;
      filt_in[i] = 0;
    end
    tick(2);
    rst = 0;
    chk_en = 1;
    tick(5);
    chk("rst_mac", 32'(mac_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_drop", 32'(wr_drop), 0);

    // Window all 1, filter 1..16: expected 136, with exact busy/done timing.
    for (int b = 0; b < 4; b++) begin
      wr(0, b, 1, 0);
      wr(1, b, 4 * b + 1, 1);
    end
    start = 1; sat_en = 0;
    for (int k = 1; k <= TAPS + 2; k++) begin
      tick(1);
      if (k == 1) start = 0;
      chk($sformatf("t2_busy_c%0d", k), 32'(busy), 32'(k <= TAPS + 1));
      chk($sformatf("t2_done_c%0d", k), 32'(done), 32'(k == TAPS + 2));
    end
    chk("t2_mac", 32'(mac_out), 136);
    chk("t2_ovf", 32'(ovf), 0);

    // All 255: saturate to 4095, then wrap to 1040400 mod 4096 = 16.
    for (int b = 0; b < 4; b++) begin
      wr(0, b, 255, 0);
      wr(1, b, 255, 0);
    end
    run(1, "t3_sat");
    chk("t3_sat_mac", 32'(mac_out), 4095);
    chk("t3_sat_ovf", 32'(ovf), 1);
    tick(1);
    chk("t3_done_single", 32'(done), 0);
    run(0, "t3_wrap");
    chk("t3_wrap_mac", 32'(mac_out), 16);
    chk("t3_wrap_ovf", 32'(ovf), 1);

    // Write and start mid-run are dropped; result reflects pre-run data.
    for (int b = 0; b < 4; b++) begin
      wr(0, b, 1, 0);
      wr(1, b, 4 * b + 1, 1);
    end
    start = 1; sat_en = 0;
    tick(1);
    start = 0;
    tick(4);
    start = 1;
    wr(1, 0, 100, 0);
    start = 0;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        dcnt++;
        chk("t4_mac", 32'(mac_out), 136);
      end
      tick(1);
    end
    chk("t4_done_count", 32'(dcnt), 1);
    chk("t4_wr_drop", 32'(wr_drop), 1);

    // Same-cycle filter write + start: 1*2*4 = 8; start also clears wr_drop.
    wr(1, 0, 9, 0);
    for (int b = 1; b < 4; b++) wr(1, b, 0, 0);
    start = 1; sat_en = 0;
    wr(1, 0, 2, 0);
    start = 0;
    chk("t5_wr_drop_clr", 32'(wr_drop), 0);
    wait_done("t5");
    chk("t5_mac", 32'(mac_out), 8);
    chk("t5_ovf", 32'(ovf), 0);

    // Reset at cycle 8 of a run: no done, outputs and buffers cleared.
    start = 1; sat_en = 0;
    tick(1);
    start = 0;
    tick(7);
    rst = 1;
    tick(1);
    rst = 0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_mac", 32'(mac_out), 0);
    chk("t6_ovf", 32'(ovf), 0);
    chk("t6_wr_drop", 32'(wr_drop), 0);
    dcnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) dcnt++;
      tick(1);
    end
    chk("t6_no_done", 32'(dcnt), 0);
    for (int b = 0; b < 4; b++) wr(0, b, 7, 0);
    run(0, "t6_rerun");
    chk("t6_rerun_mac", 32'(mac_out), 0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
